// File: rtl/register_file.sv
// 32x64 register file: two combinational read ports, one write port committing on the falling Clk edge; no backpressure.
// Optional REGFILE_WRITE_BYPASS_EN forwards BusW to any read port that addresses RW in the same cycle.
module register_file #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] RA,
  input  logic [ADDR_WIDTH-1:0] RB,
  input  logic [ADDR_WIDTH-1:0] RW,
  input  logic [DATA_WIDTH-1:0] BusW,
  input  logic                  RegWr,
  output logic [DATA_WIDTH-1:0] BusA,
  output logic [DATA_WIDTH-1:0] BusB
);

  localparam int Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs [Depth];

  // State moves only on the falling edge so the datapath can issue a write and read it back within one cycle.
  always_ff @(negedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < Depth; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWr && (RW != ZeroAddr)) begin
      regs[RW] <= BusW;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic writeLive;
  assign writeLive = RegWr && !Rst && (RW != ZeroAddr);
`endif

  always_comb begin
    BusA = (RA == ZeroAddr) ? '0 : regs[RA];
    BusB = (RB == ZeroAddr) ? '0 : regs[RB];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (writeLive && (RA == RW)) BusA = BusW;
    if (writeLive && (RB == RW)) BusB = BusW;
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// Randomised and directed bench for register_file with an array reference model and a queue-based scoreboard.
module tb_register_file;

  logic        Clk;
  logic        Rst;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic        RegWr;
  logic [63:0] BusA;
  logic [63:0] BusB;

  register_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(31)) dut (
    .Clk(Clk), .Rst(Rst), .RA(RA), .RB(RB), .RW(RW),
    .BusW(BusW), .RegWr(RegWr), .BusA(BusA), .BusB(BusB)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [63:0] mem [32];
  logic [63:0] expAQ [$];
  logic [63:0] expBQ [$];
  string       nameQ [$];
  int nCompared = 0;
  int nMismatched = 0;

  function automatic logic [63:0] rd(input logic [4:0] a);
    return (a == 5'd31) ? 64'd0 : mem[a];
  endfunction

  task automatic push(input logic [4:0] ra, input logic [4:0] rb, input string name);
    expAQ.push_back(rd(ra));
    expBQ.push_back(rd(rb));
    nameQ.push_back(name);
  endtask

  // One full clock: inputs applied after the rising edge, checked before and after the falling edge.
  task automatic cycle(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rw,
                       input logic [63:0] w, input logic we, input logic rst,
                       input logic chkPre, input logic chkPost, input string name);
    @(posedge Clk);
    #1;
    RA = ra; RB = rb; RW = rw; BusW = w; RegWr = we; Rst = rst;
    if (chkPre) push(ra, rb, {name, "_pre"});
    @(negedge Clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 64'd0;
    end else if (we && rw != 5'd31) begin
      mem[rw] = w;
    end
    if (chkPost) push(ra, rb, {name, "_post"});
  endtask

  // Monitor: two time units after the stimulus settles on each edge, pop and compare.
  initial begin
    logic [63:0] ea, eb;
    string nm;
    forever begin
      @(Clk);
      #3;
      if (expAQ.size() > 0) begin
        ea = expAQ.pop_front();
        eb = expBQ.pop_front();
        nm = nameQ.pop_front();
        nCompared++;
        if (BusA !== ea) begin
          nMismatched++;
          $display("FAIL %s BusA RA=%0d got %h expected %h", nm, RA, BusA, ea);
        end
        nCompared++;
        if (BusB !== eb) begin
          nMismatched++;
          $display("FAIL %s BusB RB=%0d got %h expected %h", nm, RB, BusB, eb);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 64'd0;
    Rst = 1'b1; RegWr = 1'b0; RA = '0; RB = '0; RW = '0; BusW = '0;

    cycle(5'd0, 5'd5, 5'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, "reset");
    cycle(5'd31, 5'd31, 5'd31, 64'h12345678, 1'b1, 1'b0, 1'b1, 1'b1, "zero_reg");

    for (int i = 0; i < 32; i++)
      cycle(5'(i), 5'((i + 1) % 32), 5'(i), 64'(i), 1'b1, 1'b0, 1'b1, 1'b1, "fill");
    for (int i = 0; i < 32; i += 2)
      cycle(5'(i), 5'(i + 1), 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, "readback");

    cycle(5'd1, 5'd14, 5'd1, 64'h1000, 1'b0, 1'b0, 1'b0, 1'b1, "wr_dis1");
    cycle(5'd1, 5'd14, 5'd14, 64'h9080009, 1'b0, 1'b0, 1'b0, 1'b1, "wr_dis14");

    cycle(5'd6, 5'd7, 5'd10, 64'h1010, 1'b1, 1'b0, 1'b1, 1'b1, "unrel_a");
    cycle(5'd8, 5'd9, 5'd11, 64'h103000, 1'b1, 1'b0, 1'b1, 1'b1, "unrel_b");
    cycle(5'd10, 5'd11, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, "unrel_rd");

    cycle(5'd12, 5'd13, 5'd13, 64'hABCD, 1'b1, 1'b0, 1'b1, 1'b1, "rdw");

    cycle(5'd5, 5'd0, 5'd5, 64'hFF, 1'b1, 1'b1, 1'b1, 1'b1, "rst_ovr");
    for (int i = 0; i < 32; i += 2)
      cycle(5'(i), 5'(i + 1), 5'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst");

    for (int n = 0; n < 400; n++) begin
      logic [63:0] w;
      w = {$urandom(), $urandom()};
      cycle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            w, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0),
            1'b1, 1'b1, "random");
    end

    @(posedge Clk);
    @(posedge Clk);
    nCompared++;
    if (expAQ.size() != 0) begin
      nMismatched++;
      $display("FAIL drain %0d expectations left, required 0", expAQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 64-bit general-purpose register file for the single-cycle datapath.
- Two combinational read ports (BusA, BusB) and one synchronous write port (BusW).
- Entry 31 is the hardwired zero register (XZR): it always reads 0 and ignores writes.
- Writes commit on the falling edge of Clk, so a write issued in one cycle is readable after that cycle's falling edge.

Parameters:
- DATA_WIDTH, 64, width of each register and of every data bus.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH = 32.
- ZERO_REG, 31, index of the hardwired zero register.

Ports:
- Clk  input  1  clock; all state updates occur on the falling edge.
- Rst  input  1  synchronous, active-high reset, sampled on the falling edge of Clk.
- RA  input  ADDR_WIDTH  read address, port A.
- RB  input  ADDR_WIDTH  read address, port B.
- RW  input  ADDR_WIDTH  write address.
- BusW  input  DATA_WIDTH  write data.
- RegWr  input  1  write enable.
- BusA  output  DATA_WIDTH  read data, port A (combinational).
- BusB  output  DATA_WIDTH  read data, port B (combinational).

Behaviour:
- Storage: 32 x 64-bit registers. The single clock is Clk; reset is synchronous and active-high.
- Reset: at a falling edge of Clk with Rst=1, all registers clear to 0, so BusA and BusB read 0 for any address. Reset overrides a simultaneous write.
- Write: at a falling edge of Clk with Rst=0, RegWr=1 and RW != ZERO_REG, set reg[RW] <= BusW.
- No write occurs when RegWr=0, or when RW == ZERO_REG (write silently discarded).
- Read: BusA = (RA == ZERO_REG) ? 0 : reg[RA]; BusB = (RB == ZERO_REG) ? 0 : reg[RB].
- Reads are purely combinational. The value must be valid within 4 ns of an address change (zero-delay RTL acceptable).
- Read-during-write to the same address (default build): before the falling edge, the read port shows the old value; after the edge, it shows the new value. No bypass.
- RA, RB and RW are independent. Both read ports may address the same register. A read port may equal RW.
- Register 0 is an ordinary writable register. Only index 31 is special.
- Rising edge of Clk has no effect.
- No X propagation after reset. Without reset, initial contents of entries 0-30 are undefined.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- When defined: if RegWr=1, Rst=0, RW != ZERO_REG and RA == RW, BusA = BusW combinationally, before the edge. Same rule for RB/BusB. This gives write-to-read forwarding in the same cycle. Reads of ZERO_REG still return 0.
- When undefined: no forwarding; behaviour is exactly as in Behaviour.
- The Test Plan assumes the macro is undefined.

Test Plan:
- Zero register: RA=RB=RW=31, BusW=0x12345678, RegWr=1, one falling edge -> BusA=BusB=0 both before and after the edge.
- Fill and read back: for i=0..31 write BusW=i to RW=i (RegWr=1), one edge each. Then read RA=0/RB=1 -> 0/1, RA=2/RB=3 -> 2/3, and so on. Read RA=31 -> 0.
- Write disabled: RW=1, BusW=0x1000, RegWr=0, edge -> reg1 still reads 1. RW=14, BusW=0x9080009, RegWr=0 -> reg14 still reads 14.
- Write with unrelated reads: RW=10, BusW=0x1010 and RW=11, BusW=0x103000, both with RegWr=1. Meanwhile reads of 6/7 and 8/9 stay unchanged. Afterward RA=10/RB=11 -> 0x1010/0x103000.
- Read-during-write: RB=RW=13, BusW=0xABCD, RegWr=1 -> BusB=13 before the falling edge, 0xABCD after it. RA=12 reads 12 throughout.
- Reset: after the fill, Rst=1 for one falling edge together with RW=5, BusW=0xFF, RegWr=1 -> all addresses read 0 and reg5 is not written.
